// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline register: slot-fill states and
// occupancy encodings.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  function automatic logic [1:0] occ_of(input pipe_state_t s);
    case (s)
      HALF:    return OCC_ONE;
      FULL:    return OCC_TWO;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One buffered bundle: valid flag plus control and data registers, with load,
// drop (invalidate only) and clear (invalidate and reset control to bubble).
module pipe_slot #(
  parameter int unsigned       DATA_W      = 128,
  parameter int unsigned       CTRL_W      = 12,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              drop,
  input  logic              clear,
  input  logic [CTRL_W-1:0] next_ctrl,
  input  logic [DATA_W-1:0] next_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Clear leaves data untouched so a squash never disturbs the datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      ctrl  <= BUBBLE_CTRL;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= BUBBLE_CTRL;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= next_ctrl;
      data  <= next_data;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake through a main+skid
// buffer with a registered ready and a synchronous flush to bubble.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 128,
  parameter int unsigned       CTRL_W      = 12,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_t state, state_next;

  logic              acc, tak;
  logic              main_load, main_drop, main_from_skid;
  logic              skid_load, skid_drop;
  logic [CTRL_W-1:0] main_next_ctrl;
  logic [DATA_W-1:0] main_next_data;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  assign acc = in_valid & in_ready;
  assign tak = main_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      // Ready is the registered image of "skid slot free after this edge".
      in_ready <= (state_next != FULL);
    end
  end

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_load  = 1'b1;
            state_next = HALF;
          end
        end
        HALF: begin
          if (acc && tak) begin
            main_load = 1'b1;
          end else if (acc) begin
            skid_load  = 1'b1;
            state_next = FULL;
          end else if (tak) begin
            main_drop  = 1'b1;
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (tak) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_drop      = 1'b1;
            state_next     = HALF;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  assign main_next_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_next_data = main_from_skid ? skid_data : in_data;

  pipe_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .drop      (main_drop),
    .clear     (flush),
    .next_ctrl (main_next_ctrl),
    .next_data (main_next_data),
    .valid     (main_valid),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  pipe_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .drop      (skid_drop),
    .clear     (flush),
    .next_ctrl (in_ctrl),
    .next_data (in_data),
    .valid     (skid_valid),
    .ctrl      (skid_ctrl),
    .data      (skid_data)
  );

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : BUBBLE_CTRL;
  assign out_data  = main_data;
  assign occupancy = 2'(main_valid) + 2'(skid_valid);

  // The slot valids and the fill state must always describe the same thing.
  a_occ_matches_state: assert property (
    @(posedge clk) disable iff (!reset) occupancy == occ_of(state)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios with literal expectations plus
// a queue-based reference compared against the outputs every cycle.
module tb_pipe_stage_reg;

  localparam int unsigned       DW  = 128;
  localparam int unsigned       CW  = 12;
  localparam logic [CW-1:0]     BUB = 12'h3C0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .BUBBLE_CTRL (BUB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two bundles; ready is registered occupancy<2.
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } bundle_t;

  bundle_t q[$];
  bit      m_ready = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_ready = 1'b0;
    end else if (flush) begin
      q.delete();
      m_ready = 1'b1;
    end else begin
      bit a, t;
      a = in_valid && m_ready;
      t = (q.size() > 0) && out_ready;
      if (t) void'(q.pop_front());
      if (a) q.push_back('{c: in_ctrl, d: in_data});
      m_ready = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    chk("m_out_valid", DW'(out_valid), DW'(q.size() > 0));
    chk("m_occupancy", DW'(occupancy), DW'(q.size()));
    chk("m_in_ready", DW'(in_ready), DW'(m_ready));
    chk("m_out_ctrl", DW'(out_ctrl), DW'((q.size() > 0) ? q[0].c : BUB));
    if (q.size() > 0) chk("m_out_data", out_data, q[0].d);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_ctrl", DW'(out_ctrl), DW'(BUB));
    chk("rst_out_data", out_data, DW'(0));
    chk("rst_occupancy", DW'(occupancy), DW'(0));
    chk("rst_in_ready", DW'(in_ready), DW'(0));

    reset = 1'b1;
    chk("rel_in_ready_before_edge", DW'(in_ready), DW'(0));
    step();
    chk("rel_in_ready", DW'(in_ready), DW'(1));

    // Single transfer, 1-cycle latency from empty.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 12'h0A5;
    in_data   = 128'h1234;
    step();
    chk("t1_out_valid", DW'(out_valid), DW'(1));
    chk("t1_out_ctrl", DW'(out_ctrl), DW'(12'h0A5));
    chk("t1_out_data", out_data, 128'h1234);
    chk("t1_occupancy", DW'(occupancy), DW'(1));
    in_valid = 1'b0;
    step();
    chk("t1_drained", DW'(out_valid), DW'(0));

    // Eight back-to-back bundles at full throughput.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_ctrl  = CW'(16 + i);
      in_data  = DW'(1000 + 7 * i);
      step();
      chk("stream_in_ready", DW'(in_ready), DW'(1));
      chk("stream_out_ctrl", DW'(out_ctrl), DW'(16 + i));
      chk("stream_out_data", out_data, DW'(1000 + 7 * i));
    end
    in_valid = 1'b0;
    step();

    // Backpressure: A then B held, then released in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 12'h111;
    in_data   = 128'hAAAA;
    step();
    in_ctrl = 12'h222;
    in_data = 128'hBBBB;
    step();
    chk("bp_occupancy", DW'(occupancy), DW'(2));
    chk("bp_in_ready", DW'(in_ready), DW'(0));
    chk("bp_head_a", DW'(out_ctrl), DW'(12'h111));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_head_b_ctrl", DW'(out_ctrl), DW'(12'h222));
    chk("bp_head_b_data", out_data, 128'hBBBB);
    chk("bp_ready_back", DW'(in_ready), DW'(1));
    chk("bp_occ_one", DW'(occupancy), DW'(1));
    step();
    chk("bp_empty", DW'(out_valid), DW'(0));

    // Flush while full with a pending input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 12'h333;
    in_data   = 128'hC3;
    step();
    in_ctrl = 12'h444;
    in_data = 128'hC4;
    step();
    chk("fl_pre_occ", DW'(occupancy), DW'(2));
    in_ctrl = 12'h555;
    in_data = 128'hC5;
    flush   = 1'b1;
    step();
    chk("fl_out_valid", DW'(out_valid), DW'(0));
    chk("fl_out_ctrl", DW'(out_ctrl), DW'(BUB));
    chk("fl_occupancy", DW'(occupancy), DW'(0));
    chk("fl_in_ready", DW'(in_ready), DW'(1));
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_no_ghost", DW'(out_valid), DW'(0));

    // Asynchronous reset between edges, mid-stream.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_ctrl = CW'(12'h600 + i);
      in_data = DW'(12'h600 + i);
      step();
    end
    #2;
    reset = 1'b0;
    #1;
    chk("ar_out_valid", DW'(out_valid), DW'(0));
    chk("ar_in_ready", DW'(in_ready), DW'(0));
    chk("ar_occupancy", DW'(occupancy), DW'(0));
    chk("ar_out_ctrl", DW'(out_ctrl), DW'(BUB));
    chk("ar_out_data", out_data, DW'(0));
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("ar_release_ready", DW'(in_ready), DW'(1));

    // Random traffic against the reference queue.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 96) == 0);
      in_ctrl   = CW'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("final_empty", DW'(occupancy), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register: the next generation of the inter-stage latch used between the processor's pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Control and data fields are carried with a valid/ready handshake through a two-entry skid buffer, so that a stall propagates upstream one stage per cycle with no combinational ready path. A synchronous flush squashes in-flight contents into a bubble. One instance sits at each stage boundary; the control and data bundles are packed by the surrounding stage logic.

## Interface
- `DATA_W`, default 128: packed data bundle width (operands, immediates, register numbers).
- `CTRL_W`, default 12: packed control bundle width (RegWrite, MemRead, ALUOp, ...).
- `BUBBLE_CTRL`, default 0: control value presented on `out_ctrl` whenever `out_valid`=0.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash, active-high.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept; registered output.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `in_data`  in  DATA_W  upstream data bundle.
- `out_valid`  out  1  downstream bundle valid.
- `out_ready`  in  1  downstream accepts.
- `out_ctrl`  out  CTRL_W  control bundle (BUBBLE_CTRL when invalid).
- `out_data`  out  DATA_W  data bundle (don't-care when invalid).
- `occupancy`  out  2  entries held: 0, 1, 2.

## Operation
- Two slots: main (drives outputs) and skid. States: EMPTY (none valid), HALF (main valid), FULL (main and skid valid).
- Input transfer `acc` = in_valid & in_ready. Output transfer `tak` = out_valid & out_ready.
- EMPTY: acc → main<=in, HALF.
- HALF: acc & tak → main<=in, stay HALF; acc & !tak → skid<=in, FULL; !acc & tak → EMPTY; otherwise hold.
- FULL: in_ready=0, so no acc. tak → main<=skid, HALF; otherwise hold.
- `in_ready` = !skid_valid, registered; forced to 0 while reset is asserted.
- `out_valid` = main_valid. `out_ctrl` = main_valid ? main_ctrl : BUBBLE_CTRL.
- `occupancy` = main_valid + skid_valid.
- Flush has the highest priority. On the edge where it is sampled: both valids clear, state EMPTY, any acc or tak that cycle is discarded (upstream must treat an acc as consumed). Data registers hold their values; control registers load BUBBLE_CTRL.
- Reset (asynchronous assert, synchronous release): state EMPTY, valids 0, ctrl registers BUBBLE_CTRL, data registers 0. Resulting outputs: out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, occupancy=0, in_ready=0 while asserted and 1 on the first cycle after release.
- Data is never modified in flight. Bundle widths pass through as-is; there is no arithmetic.

## Timing
- Latency: in→out is 1 cycle when EMPTY, or HALF with tak.
- Throughput: 1 bundle per cycle sustained while out_ready=1.
- Backpressure: out_ready low reaches in_ready after 1 cycle. The skid slot absorbs the one bundle accepted in flight.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- Ordering is strictly FIFO. No bundle is dropped or duplicated except under flush.
- Reset asserted mid-transfer: all contents are lost and no partial update occurs.

## Structure
- Shared package `pipe_pkg`: the `pipe_state_t` enum {EMPTY, HALF, FULL} and the occupancy constants OCC_EMPTY/OCC_ONE/OCC_TWO.
- A natural sub-module is `pipe_slot`: a valid+ctrl+data register with load and clear enables, instantiated twice (main, skid).
- Stage-specific bundle packing stays in the instantiating stage, not in this block.

## Test plan
- Reset release, then in_valid=1, in_ctrl=12'h0A5, in_data=128'h1234, out_ready=1 → next cycle out_valid=1, out_ctrl=12'h0A5, out_data=128'h1234, occupancy=1.
- Stream of 8 bundles with out_ready held at 1 → 8 consecutive out_valid cycles, values in order, in_ready never 0.
- out_ready=0 while sending A then B → occupancy=2 and in_ready=0 on the cycle after B. Then out_ready=1 → A then B emitted on consecutive cycles, and in_ready=1 one cycle after A leaves.
- flush=1 with occupancy=2 and in_valid=1 → next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0, in_ready=1; the flushed input never appears.
- reset driven low asynchronously mid-stream, between edges → out_valid=0, in_ready=0 and occupancy=0 immediately, without waiting for a clock edge.
- Random in_valid/out_ready over 10k cycles, checked against a FIFO scoreboard → no loss, duplication or reordering, and occupancy is never above 2.
